// File: rtl/rtc_time_reader.sv
// I2C read-back sequencer for the RTC time registers: pointer write, repeated START,
// burst read of seven BCD bytes, then an atomic update of the snapshot outputs.
module rtc_time_reader #(
   parameter int         CLK_DIV   = 250,
   parameter logic [6:0] DEV_ADDR  = 7'h68,
   parameter logic [7:0] START_REG = 8'h00,
   parameter int         NUM_REGS  = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in,
   output logic       busy,
   output logic       done,
   output logic       nack_err,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic [7:0] hour,
   output logic [7:0] day,
   output logic [7:0] date,
   output logic [7:0] month,
   output logic [7:0] year
);

   localparam int               DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [2:0]       K_LAST   = 3'(NUM_REGS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_TX_BYTE, S_TX_ACK, S_RSTART,
      S_RX_BYTE, S_RX_ACK, S_STOP, S_FINISH
   } state_t;

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [1:0]       q_reg, q_next;
   logic [2:0]       bit_reg, bit_next;
   logic [7:0]       tx_reg, tx_next;
   logic [1:0]       phase_reg, phase_next;   // 0: write address, 1: pointer, 2: read address
   logic [2:0]       k_reg, k_next;
   logic [7:0]       rx_reg, rx_next;
   logic             ack_reg, ack_next;
   logic             nack_next;
   logic             quarter_end, bit_end, sample_pt;
   logic [7:0]       shadow [0:NUM_REGS-1];
   logic [7:0]       snap_reg [0:NUM_REGS-1];

   assign quarter_end = (div_reg == DIV_LAST);
   assign bit_end     = quarter_end && (q_reg == 2'd3);
   assign sample_pt   = quarter_end && (q_reg == 2'd1);

   // Bus levels {scl, sda_oe} as a pure function of the sequencer position.
   function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] qq,
                                             input logic tx_msb, input logic [2:0] kk);
      logic clk_phase;
      clk_phase = qq[0] ^ qq[1];
      case (st)
         S_START:             bus_levels = {qq != 2'd3, qq[1]};
         S_TX_BYTE:           bus_levels = {clk_phase, ~tx_msb};
         S_TX_ACK, S_RX_BYTE: bus_levels = {clk_phase, 1'b0};
         S_RSTART:            bus_levels = {clk_phase, qq[1]};
         S_RX_ACK:            bus_levels = {clk_phase, kk != K_LAST};
         S_STOP:              bus_levels = {qq != 2'd0, ~qq[1]};
         default:             bus_levels = 2'b10;
      endcase
   endfunction

   always_comb begin
      state_next = state_reg;
      div_next   = div_reg;
      q_next     = q_reg;
      bit_next   = bit_reg;
      tx_next    = tx_reg;
      phase_next = phase_reg;
      k_next     = k_reg;
      rx_next    = rx_reg;
      ack_next   = ack_reg;
      nack_next  = nack_err;

      if (state_reg != S_IDLE && state_reg != S_FINISH) begin
         div_next = quarter_end ? '0 : div_reg + DIV_W'(1);
         if (quarter_end)
            q_next = q_reg + 2'd1;
      end

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_START;
               nack_next  = 1'b0;
               tx_next    = {DEV_ADDR, 1'b0};
               phase_next = 2'd0;
               k_next     = 3'd0;
            end
         end
         S_START: begin
            if (bit_end)
               state_next = S_TX_BYTE;
         end
         S_TX_BYTE: begin
            if (bit_end) begin
               tx_next  = {tx_reg[6:0], 1'b0};
               bit_next = bit_reg + 3'd1;
               if (bit_reg == 3'd7)
                  state_next = S_TX_ACK;
            end
         end
         S_TX_ACK: begin
            if (sample_pt)
               ack_next = sda_in;
            if (bit_end) begin
               if (ack_reg) begin
                  nack_next  = 1'b1;
                  state_next = S_STOP;
               end else begin
                  case (phase_reg)
                     2'd0: begin
                        tx_next    = START_REG;
                        phase_next = 2'd1;
                        state_next = S_TX_BYTE;
                     end
                     2'd1: begin
                        tx_next    = {DEV_ADDR, 1'b1};
                        phase_next = 2'd2;
                        state_next = S_RSTART;
                     end
                     default: state_next = S_RX_BYTE;
                  endcase
               end
            end
         end
         S_RSTART: begin
            if (bit_end)
               state_next = S_TX_BYTE;
         end
         S_RX_BYTE: begin
            if (sample_pt)
               rx_next = {rx_reg[6:0], sda_in};
            if (bit_end) begin
               bit_next = bit_reg + 3'd1;
               if (bit_reg == 3'd7)
                  state_next = S_RX_ACK;
            end
         end
         S_RX_ACK: begin
            if (bit_end) begin
               if (k_reg == K_LAST) begin
                  state_next = S_STOP;
               end else begin
                  k_next     = k_reg + 3'd1;
                  state_next = S_RX_BYTE;
               end
            end
         end
         S_STOP: begin
            if (bit_end)
               state_next = S_FINISH;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         div_reg   <= '0;
         q_reg     <= 2'd0;
         bit_reg   <= 3'd0;
         tx_reg    <= 8'h00;
         phase_reg <= 2'd0;
         k_reg     <= 3'd0;
         rx_reg    <= 8'h00;
         ack_reg   <= 1'b0;
         nack_err  <= 1'b0;
         scl       <= 1'b1;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++)
            snap_reg[i] <= 8'h00;
      end else begin
         state_reg       <= state_next;
         div_reg         <= div_next;
         q_reg           <= q_next;
         bit_reg         <= bit_next;
         tx_reg          <= tx_next;
         phase_reg       <= phase_next;
         k_reg           <= k_next;
         rx_reg          <= rx_next;
         ack_reg         <= ack_next;
         nack_err        <= nack_next;
         {scl, sda_oe}   <= bus_levels(state_next, q_next, tx_next[7], k_next);
         busy            <= (state_next != S_IDLE);
         done            <= (state_next == S_FINISH);
         // Publish all bytes together so done and the fresh snapshot appear in the same cycle.
         if (state_reg == S_STOP && bit_end && !nack_err) begin
            for (int i = 0; i < NUM_REGS; i++)
               snap_reg[i] <= shadow[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_reg == S_RX_BYTE && bit_end && bit_reg == 3'd7)
         shadow[k_reg] <= rx_reg;
   end

   assign sec   = snap_reg[0];
   assign min   = snap_reg[1];
   assign hour  = snap_reg[2];
   assign day   = snap_reg[3];
   assign date  = snap_reg[4];
   assign month = snap_reg[5];
   assign year  = snap_reg[6];

endmodule

// File: tb/tb_rtc_time_reader.sv
// Bench for rtc_time_reader: behavioural RTC slave, bus-token scoreboard and
// done-time result scoreboard, plus SCL timing checks on every transaction.
module tb_rtc_time_reader;

   localparam int          CD      = 4;
   localparam int          BIT     = 4 * CD;
   localparam logic [11:0] TOK_S   = 12'h400;
   localparam logic [11:0] TOK_P   = 12'h800;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        scl, sda_oe, sda_in, busy, done, nack_err;
   logic [7:0]  sec, min, hour, day, date, month, year;
   logic        slave_pull = 1'b0;
   logic [55:0] snap_out;

   rtc_time_reader #(.CLK_DIV(CD), .DEV_ADDR(7'h68), .START_REG(8'h00), .NUM_REGS(7)) dut (
      .clk(clk), .reset(reset), .start(start), .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in),
      .busy(busy), .done(done), .nack_err(nack_err), .sec(sec), .min(min), .hour(hour),
      .day(day), .date(date), .month(month), .year(year)
   );

   assign sda_in   = ~(sda_oe | slave_pull);
   assign snap_out = {sec, min, hour, day, date, month, year};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic        nack;
      logic [55:0] snap;
      logic [31:0] lat;
   } res_t;

   logic [11:0] exp_tok [$];
   res_t        exp_res [$];
   logic [7:0]  mem [0:7];
   logic [55:0] model_snap = '0;
   int          t0 = 0;
   int          done_cnt = 0;
   int          busy_rises = 0;
   logic        busy_prev = 1'b0;
   logic        cfg_nack_addr = 1'b0;
   logic        cfg_nack_reg = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic pop_tok(input logic [11:0] got);
      if (exp_tok.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL bus_token: got %03h, expected none (cycle %0d)", got, cyc);
      end else begin
         check("bus_token", got, exp_tok.pop_front());
      end
   endtask

   // Behavioural RTC slave: ACKs its address and the pointer, then streams mem[ptr..].
   logic       s_prev_scl = 1'b1, s_prev_sda = 1'b1;
   int         s_n = 0, s_phase = 0;
   logic       s_skip = 1'b0, s_ack = 1'b0, s_mack = 1'b0, s_rw = 1'b0;
   logic [7:0] s_shift = 8'h00, s_tx = 8'h00, s_ptr = 8'h00;

   always @(negedge clk) begin
      if (reset) begin
         slave_pull = 1'b0;
         s_phase    = 0;
         s_n        = 0;
         s_skip     = 1'b0;
         s_prev_scl = scl;
         s_prev_sda = sda_in;
      end else begin
         if (s_prev_scl && scl && s_prev_sda != sda_in) begin
            if (!sda_in) begin
               s_phase = 1; s_n = 0; s_skip = 1'b1;
            end else begin
               s_phase = 0; slave_pull = 1'b0;
            end
         end else if (!s_prev_scl && scl) begin
            if (s_n < 8) s_shift = {s_shift[6:0], sda_in};
            else         s_mack = sda_in;
         end else if (s_prev_scl && !scl) begin
            if (s_skip) begin
               s_skip = 1'b0;
            end else if (s_phase != 0) begin
               s_n++;
               if (s_n == 8) begin
                  case (s_phase)
                     1: begin
                        s_ack = (s_shift[7:1] == 7'h68) && !cfg_nack_addr;
                        s_rw = s_shift[0];
                        slave_pull = s_ack;
                     end
                     2: begin
                        s_ack = !cfg_nack_reg;
                        s_ptr = s_shift;
                        slave_pull = s_ack;
                     end
                     default: slave_pull = 1'b0;
                  endcase
               end else if (s_n == 9) begin
                  s_n = 0;
                  slave_pull = 1'b0;
                  case (s_phase)
                     1: begin
                        if (!s_ack) s_phase = 0;
                        else if (s_rw) begin
                           s_phase = 3;
                           s_tx = mem[s_ptr[2:0]];
                           slave_pull = ~s_tx[7];
                        end else s_phase = 2;
                     end
                     2: s_phase = 0;
                     default: begin
                        if (!s_mack) begin
                           s_ptr = s_ptr + 8'd1;
                           s_tx = mem[s_ptr[2:0]];
                           slave_pull = ~s_tx[7];
                        end else s_phase = 0;
                     end
                  endcase
               end else if (s_phase == 3) begin
                  slave_pull = ~s_tx[7 - s_n];
               end
            end
         end
         s_prev_scl = scl;
         s_prev_sda = sda_in;
      end
   end

   // Bus monitor: decodes START/STOP/bytes into tokens and times SCL phases.
   logic       m_prev_scl = 1'b1, m_prev_sda = 1'b1;
   int         m_n = 0, t_edge = 0;
   logic [8:0] m_bits = '0;
   logic       t_valid = 1'b0, stop_seen = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         m_n        = 0;
         t_valid    = 1'b0;
         m_prev_scl = scl;
         m_prev_sda = sda_in;
      end else begin
         if (m_prev_scl && scl && m_prev_sda != sda_in) begin
            pop_tok(sda_in ? TOK_P : TOK_S);
            m_n = 0;
            if (sda_in) stop_seen = 1'b1;
         end else if (!m_prev_scl && scl) begin
            if (t_valid) check("scl_low_time", 64'(cyc - t_edge), 64'(2 * CD));
            t_edge = cyc; t_valid = 1'b1; stop_seen = 1'b0;
            m_bits = {m_bits[7:0], sda_in};
            m_n++;
            if (m_n == 9) begin
               pop_tok({3'b000, m_bits});
               m_n = 0;
            end
         end else if (m_prev_scl && !scl) begin
            if (t_valid && !stop_seen) check("scl_high_time", 64'(cyc - t_edge), 64'(2 * CD));
            t_edge = cyc; t_valid = 1'b1;
         end
         m_prev_scl = scl;
         m_prev_sda = sda_in;
      end
   end

   // Result monitor: one expected entry per completed transaction.
   always @(negedge clk) begin
      if (busy && !busy_prev) busy_rises++;
      busy_prev = busy;
      if (!reset && done) begin
         done_cnt++;
         if (exp_res.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL done_unexpected: got done=1, expected no pulse (cycle %0d)", cyc);
         end else begin
            res_t r;
            r = exp_res.pop_front();
            check("done_nack", 64'(nack_err), 64'(r.nack));
            check("done_snap", 64'(snap_out), 64'(r.snap));
            check("done_latency", 64'(cyc - t0), 64'(r.lat));
            check("done_busy", 64'(busy), 64'd1);
         end
      end
   end

   task automatic push_read_tokens(input int last);
      exp_tok.push_back(TOK_S);
      exp_tok.push_back({3'b000, 8'hD1, 1'b0});
      for (int i = 0; i <= last; i++)
         exp_tok.push_back({3'b000, mem[i], (i == 6)});
   endtask

   task automatic run_txn(input logic na, input logic nr, input int hold, input int repulse_at);
      res_t r;
      int   d0;
      cfg_nack_addr = na;
      cfg_nack_reg  = nr;
      exp_tok.push_back(TOK_S);
      exp_tok.push_back({3'b000, 8'hD0, na});
      if (!na) begin
         exp_tok.push_back({3'b000, 8'h00, nr});
         if (!nr) push_read_tokens(6);
      end
      exp_tok.push_back(TOK_P);
      if (!na && !nr)
         model_snap = {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]};
      r.nack = na | nr;
      r.snap = model_snap;
      r.lat  = na ? 32'd177 : (nr ? 32'd321 : 32'd1489);
      exp_res.push_back(r);
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      check("accept_busy", 64'(busy), 64'd1);
      check("accept_nack_clr", 64'(nack_err), 64'd0);
      repeat (hold - 1) @(negedge clk);
      start = 1'b0;
      if (repulse_at > 0) begin
         repeat (repulse_at) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
      if (done_cnt == d0) begin
         compared++;
         mismatched++;
         $display("FAIL done_timeout: got no done, expected one within 4000 cycles");
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before 2000000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mem[0] = 8'h59; mem[1] = 8'h59; mem[2] = 8'h23; mem[3] = 8'h07;
      mem[4] = 8'h31; mem[5] = 8'h12; mem[6] = 8'h99; mem[7] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_scl", 64'(scl), 64'd1);
      check("rst_sda_oe", 64'(sda_oe), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_nack", 64'(nack_err), 64'd0);
      check("rst_snap", 64'(snap_out), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_txn(1'b0, 1'b0, 1, 0);     // full read
      run_txn(1'b1, 1'b0, 1, 0);     // address NACK, snapshot kept
      run_txn(1'b0, 1'b0, 1, 0);     // good slave clears nack_err
      run_txn(1'b0, 1'b1, 1, 0);     // pointer NACK, no repeated START
      run_txn(1'b0, 1'b0, 3, 400);   // held and repeated start

      // Abort with reset while the fourth data byte is on the bus.
      cfg_nack_addr = 1'b0;
      cfg_nack_reg  = 1'b0;
      exp_tok.push_back(TOK_S);
      exp_tok.push_back({3'b000, 8'hD0, 1'b0});
      exp_tok.push_back({3'b000, 8'h00, 1'b0});
      push_read_tokens(2);
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3000 && exp_tok.size() != 0; i++) @(negedge clk);
      check("abort_tokens_left", 64'(exp_tok.size()), 64'd0);
      exp_tok.delete();
      repeat (3 * BIT) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_scl", 64'(scl), 64'd1);
      check("abort_sda_oe", 64'(sda_oe), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_snap", 64'(snap_out), 64'd0);
      model_snap = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h01;
      mem[4] = 8'h15; mem[5] = 8'h08; mem[6] = 8'h25;
      run_txn(1'b0, 1'b0, 1, 0);

      repeat (10) @(negedge clk);
      check("busy_rises", 64'(busy_rises), 64'd7);
      check("done_count", 64'(done_cnt), 64'd6);
      check("tokens_left", 64'(exp_tok.size()), 64'd0);
      check("results_left", 64'(exp_res.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rtc_time_reader.md
Name: rtc_time_reader

Overview:
- I2C read-back sequencer for the RTC time-keeping registers; the read-side counterpart of the RTC write/initialise sequencer.
- On a start pulse it issues START, device address + W, register pointer, repeated START, device address + R, then reads NUM_REGS consecutive bytes and issues STOP.
- Presents the seconds-to-year BCD registers to downstream display/logging logic as one atomic snapshot.
- SDA uses a split open-drain interface; the top level builds the tristate.

Parameters:
- CLK_DIV, 250: clk cycles per SCL quarter-period. One bit lasts 4*CLK_DIV cycles. Minimum legal value 2.
- DEV_ADDR, 7'h68: 7-bit I2C slave address.
- START_REG, 8'h00: first register pointer written before the read.
- NUM_REGS, 7: bytes read. Fixed at 7 for this block, mapped sec, min, hour, day, date, month, year.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- scl  out  1  I2C clock, push-pull
- sda_oe  out  1  1 = pull SDA low, 0 = release SDA (pulled high externally)
- sda_in  in  1  sampled SDA line
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse when a transaction completes, with or without error
- nack_err  out  1  sticky; set on any slave NACK; cleared by the next accepted start
- sec, min, hour, day, date, month, year  out  8 each  snapshot registers, BCD as stored by the RTC

Behaviour:
- Reset values: scl=1, sda_oe=0, busy=0, done=0, nack_err=0, all snapshot registers 8'h00, FSM=IDLE, all counters 0.
- Reset asserted mid-transaction: same values as above, applied immediately. No STOP is generated.
- Bit timing: quarter counter q counts 0..3, each quarter lasting CLK_DIV clk cycles.
  - scl=0 in q0 and q3; scl=1 in q1 and q2.
  - sda_oe changes only at the start of q0.
  - sda_in is sampled on the last cycle of q1.
- FSM states: IDLE, START, TX_BYTE, TX_ACK, RSTART, RX_BYTE, RX_ACK, STOP, FINISH.
- IDLE: scl=1, sda_oe=0. start=1 -> busy=1, nack_err cleared, go to START. start=1 in any other state is ignored.
- START: SDA falls while SCL is high (q0-q1 sda_oe=0, q2-q3 sda_oe=1, scl=1 through q2, scl=0 in q3). Then TX_BYTE with the byte {DEV_ADDR,1'b0}.
- TX_BYTE: 8 bits, MSB first. sda_oe = ~bit. Then TX_ACK.
- TX_ACK: sda_oe=0 and sda_in is sampled.
  - sda_in=1 (NACK): nack_err=1, go to STOP.
  - ACK after the write address: TX_BYTE with START_REG.
  - ACK after START_REG: go to RSTART.
  - ACK after the read address: go to RX_BYTE with byte index k=0.
- RSTART: q0 sda_oe=0 with scl=0, q1 scl=1, q2 sda_oe=1 with scl high, q3 scl=0. Then TX_BYTE with {DEV_ADDR,1'b1}.
- RX_BYTE: sda_oe=0. 8 bits are shifted in MSB first into shadow[k]. Then RX_ACK.
- RX_ACK: master drives ACK (sda_oe=1) if k<NUM_REGS-1, otherwise NACK (sda_oe=0).
  - k<NUM_REGS-1: increment k, return to RX_BYTE.
  - Last byte: go to STOP.
- STOP: q0 sda_oe=1 with scl=0, q1-q2 scl=1, q2 sda_oe=0 (SDA rises while SCL high), q3 scl=1. Then FINISH.
- FINISH: lasts one cycle.
  - No error: copy all 7 shadow bytes to the outputs in this cycle.
  - With error: outputs keep their previous values.
  - done=1, then busy=0 and IDLE on the next cycle.
- Snapshot outputs never show a partially read set.
- No clock stretching and no arbitration. A slave holding SCL low is out of scope.
- Transaction length with no error: start + 1 + 2*9 + 1 + 9 + 7*9 + 1 bit periods + 2 cycles.

Test Plan:
- CLK_DIV=4, slave model at 0x68 ACKs everything and returns 59,59,23,07,31,12,99 (hex BCD); pulse start -> START, 0xD0, 0x00, repeated START, 0xD1 on the bus; outputs sec=8'h59 ... year=8'h99; master ACKs 6 bytes and NACKs the 7th; done pulses once; nack_err=0.
- Slave NACKs the address byte 0xD0 -> STOP issued right after the first ACK slot; nack_err=1; done=1; outputs keep their prior values; next start with a good slave clears nack_err.
- Slave NACKs the register pointer 0x00 -> immediate STOP; nack_err=1; no repeated START appears on the bus.
- start held high for 3 cycles and re-pulsed mid-transaction -> exactly one transaction; busy stays continuously high.
- Assert reset during RX_BYTE byte 3 -> same cycle: scl=1, sda_oe=0, busy=0, outputs 8'h00; a following start completes normally.
- Protocol checker on every run: SDA (the inverse of sda_oe) changes while scl=1 only at START/RSTART/STOP; sampling happens only while scl=1; SCL high and low times are each 2*CLK_DIV cycles.
